// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute-stage ALU. Single-cycle ops (logic, add/sub, compares,
//            pass) produce a registered result one cycle after accept.
//            Shifts run serially, up to SHIFT_STEP bit positions per cycle,
//            under a two-state FSM (IDLE / SHIFT).
// Ports    :
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   flush      in   1    synchronous abort of in-flight shift / pending result
//   in_valid   in   1    operation and operands valid
//   in_ready   out  1    unit accepts this cycle
//   operation  in   4    op code
//   src_a      in   DW   operand A / shift source
//   src_b      in   DW   operand B / shift amount (low log2(DW) bits)
//   out_valid  out  1    result / zero valid
//   out_ready  in   1    consumer takes result
//   result     out  DW   registered result
//   zero       out  1    registered (result == 0)
//   busy       out  1    high while in SHIFT
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  busy
);

  localparam int AW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Remaining shift amount never exceeds DATA_WIDTH-1, so the per-cycle
  // step can be capped there and always fits in AW bits.
  localparam int STEP_CAP = (SHIFT_STEP > DATA_WIDTH - 1) ? DATA_WIDTH - 1 : SHIFT_STEP;
  localparam logic [AW-1:0] c_step_cap = AW'(STEP_CAP);

  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_xor  = 4'b0011;
  localparam logic [3:0] c_op_passb = 4'b0100;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_eq   = 4'b0111;
  localparam logic [3:0] c_op_ne   = 4'b1000;
  localparam logic [3:0] c_op_lt   = 4'b1001;
  localparam logic [3:0] c_op_ge   = 4'b1010;
  localparam logic [3:0] c_op_ltu  = 4'b1011;
  localparam logic [3:0] c_op_geu  = 4'b1100;
  localparam logic [3:0] c_op_sll  = 4'b1101;
  localparam logic [3:0] c_op_sra  = 4'b1110;
  localparam logic [3:0] c_op_srl  = 4'b1111;

  // Low two op bits identify the shift kind once captured.
  localparam logic [1:0] c_sh_sll = 2'b01;
  localparam logic [1:0] c_sh_sra = 2'b10;
  localparam logic [1:0] c_sh_srl = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic [DATA_WIDTH-1:0] sh_val_q, sh_val_d;
  logic [AW-1:0]         sh_amt_q, sh_amt_d;
  logic [1:0]            sh_op_q, sh_op_d;

  // --------------------------------------------------------------------------
  // Single-cycle datapath. Operands are masked when in_valid is low so that
  // undriven inputs never reach the result path.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [AW-1:0]         b_amt;
  logic                  is_shift;
  logic                  cond;
  logic [DATA_WIDTH-1:0] alu_res;

  assign op_a     = in_valid ? src_a : '0;
  assign op_b     = in_valid ? src_b : '0;
  assign b_amt    = op_b[AW-1:0];
  assign is_shift = (operation == c_op_sll) || (operation == c_op_sra) ||
                    (operation == c_op_srl);

  always_comb begin
    cond    = 1'b0;
    alu_res = '0;
    case (operation)
      c_op_and:   alu_res = op_a & op_b;
      c_op_or:    alu_res = op_a | op_b;
      c_op_add:   alu_res = op_a + op_b;
      c_op_xor:   alu_res = op_a ^ op_b;
      c_op_passb: alu_res = op_b;
      c_op_sub:   alu_res = op_a - op_b;
      c_op_eq:    cond = (op_a == op_b);
      c_op_ne:    cond = (op_a != op_b);
      c_op_lt:    cond = ($signed(op_a) <  $signed(op_b));
      c_op_ge:    cond = ($signed(op_a) >= $signed(op_b));
      c_op_ltu:   cond = (op_a <  op_b);
      c_op_geu:   cond = (op_a >= op_b);
      // A shift by zero completes in one cycle and simply returns src_a.
      c_op_sll, c_op_sra, c_op_srl: alu_res = op_a;
      default:    alu_res = '0;
    endcase
    case (operation)
      c_op_eq, c_op_ne, c_op_lt, c_op_ge, c_op_ltu, c_op_geu:
        alu_res = {{(DATA_WIDTH-1){1'b0}}, cond};
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Serial shifter: one step of min(SHIFT_STEP, remaining) positions.
  // --------------------------------------------------------------------------
  logic [AW-1:0]         step;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    step = (sh_amt_q > c_step_cap) ? c_step_cap : sh_amt_q;
  end

  always_comb begin
    shifted = sh_val_q;
    case (sh_op_q)
      c_sh_sll: shifted = sh_val_q << step;
      c_sh_sra: shifted = $unsigned($signed(sh_val_q) >>> step);
      c_sh_srl: shifted = sh_val_q >> step;
      default:  shifted = sh_val_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake. in_ready is forced low while reset is asserted even though
  // the registers already sit at their IDLE reset values.
  // --------------------------------------------------------------------------
  assign in_ready = rst_n && (state_q == ST_IDLE) && !flush &&
                    (!out_valid_q || out_ready);

  // --------------------------------------------------------------------------
  // Next-state / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    sh_val_d    = sh_val_q;
    sh_amt_d    = sh_amt_q;
    sh_op_d     = sh_op_q;

    if (flush) begin
      // Abort: drop the shift and any pending result, keep result/zero.
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end
          if (in_valid && in_ready) begin
            if (is_shift && (b_amt != '0)) begin
              sh_val_d    = op_a;
              sh_amt_d    = b_amt;
              sh_op_d     = operation[1:0];
              state_d     = ST_SHIFT;
              out_valid_d = 1'b0;
            end else begin
              result_d    = alu_res;
              zero_d      = (alu_res == '0);
              out_valid_d = 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          sh_val_d = shifted;
          sh_amt_d = sh_amt_q - step;
          if (sh_amt_q == step) begin
            result_d    = shifted;
            zero_d      = (shifted == '0);
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end

        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      sh_val_q    <= '0;
      sh_amt_q    <= '0;
      sh_op_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      sh_val_q    <= sh_val_d;
      sh_amt_q    <= sh_amt_d;
      sh_op_q     <= sh_op_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Self-checking bench for alu_exec_unit. A cycle-level behavioural
//            model (remaining-latency counter plus pending result) predicts
//            every output each cycle; directed vectors pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int DW   = 32;
  localparam int STEP = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    operation = 4'd0;
  logic [DW-1:0] src_a = '0;
  logic [DW-1:0] src_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] result;
  logic          zero;
  logic          busy;

  alu_exec_unit #(.DATA_WIDTH(DW), .SHIFT_STEP(STEP)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  function automatic logic [DW-1:0] model_res(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    int n;
    n = int'(b[4:0]);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return b;
      4'd6:  return a - b;
      4'd7:  return (a == b) ? 32'd1 : 32'd0;
      4'd8:  return (a != b) ? 32'd1 : 32'd0;
      4'd9:  return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      4'd10: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd11: return (a <  b) ? 32'd1 : 32'd0;
      4'd12: return (a >= b) ? 32'd1 : 32'd0;
      4'd13: return a << n;
      4'd14: return $unsigned($signed(a) >>> n);
      4'd15: return a >> n;
      default: return '0;
    endcase
  endfunction

  function automatic int shift_cycles(input logic [3:0] op, input logic [DW-1:0] b);
    int n;
    n = int'(b[4:0]);
    if (op >= 4'd13) return (n + STEP - 1) / STEP;
    return 0;
  endfunction

  int            m_cnt;   // SHIFT cycles still to run
  logic [DW-1:0] m_pend;
  logic [DW-1:0] m_res;
  logic          m_zero;
  logic          m_ov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_ov   = 1'b0;
      m_res  = '0;
      m_zero = 1'b1;
      m_pend = '0;
    end else if (flush) begin
      m_cnt = 0;
      m_ov  = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_ov   = 1'b1;
        m_res  = m_pend;
        m_zero = (m_pend == '0);
      end
    end else begin
      logic rdy;
      rdy = !m_ov || out_ready;
      if (m_ov && out_ready) m_ov = 1'b0;
      if (in_valid && rdy) begin
        if (shift_cycles(operation, src_b) == 0) begin
          m_res  = model_res(operation, src_a, src_b);
          m_zero = (m_res == '0);
          m_ov   = 1'b1;
        end else begin
          m_cnt  = shift_cycles(operation, src_b);
          m_pend = model_res(operation, src_a, src_b);
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = rst_n && (m_cnt == 0) && !flush && (!m_ov || out_ready);
    chk("model in_ready",  64'(in_ready),  64'(exp_rdy));
    chk("model out_valid", 64'(out_valid), 64'(m_ov));
    chk("model busy",      64'(busy),      64'(m_cnt > 0));
    chk("model result",    64'(result),    64'(m_res));
    chk("model zero",      64'(zero),      64'(m_zero));
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] r;
    int            lat;
    string         name;
  } vec_t;

  vec_t vecs[19] = '{
    '{4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1,  "ADD wrap"},
    '{4'd6,  32'd5,         32'd5,         32'd0,         1,  "SUB zero"},
    '{4'd7,  32'd7,         32'd7,         32'd1,         1,  "EQ"},
    '{4'd9,  32'hFFFF_FFFF, 32'd1,         32'd1,         1,  "LT signed"},
    '{4'd11, 32'hFFFF_FFFF, 32'd1,         32'd0,         1,  "LTU"},
    '{4'd5,  32'd3,         32'd4,         32'd0,         1,  "op5"},
    '{4'd0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1,  "AND"},
    '{4'd1,  32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1,  "OR"},
    '{4'd3,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1,  "XOR"},
    '{4'd4,  32'd0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1,  "PASS_B"},
    '{4'd8,  32'd7,         32'd8,         32'd1,         1,  "NE"},
    '{4'd10, 32'hFFFF_FFFE, 32'd1,         32'd0,         1,  "GE signed"},
    '{4'd12, 32'hFFFF_FFFE, 32'd1,         32'd1,         1,  "GEU"},
    '{4'd6,  32'd0,         32'd1,         32'hFFFF_FFFF, 1,  "SUB wrap"},
    '{4'd13, 32'd1,         32'd31,        32'h8000_0000, 32, "SLL 31"},
    '{4'd14, 32'h8000_0000, 32'd4,         32'hF800_0000, 5,  "SRA 4"},
    '{4'd15, 32'h8000_0000, 32'd4,         32'h0800_0000, 5,  "SRL 4"},
    '{4'd13, 32'h0000_1234, 32'd0,         32'h0000_1234, 1,  "SLL 0"},
    '{4'd14, 32'h0000_00F0, 32'h0000_0024, 32'h0000_000F, 5,  "SRA low bits"}
  };

  // Entered and left at posedge+1.
  task automatic run_op(input vec_t v, output int busy_cnt);
    int guard;
    int lat;
    in_valid  = 1'b1;
    operation = v.op;
    src_a     = v.a;
    src_b     = v.b;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready || guard > 100) break;
      guard++;
    end
    chk({v.name, " accept"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end while (!out_valid && lat < 100);
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " result"}, 64'(result), 64'(v.r));
    chk({v.name, " zero"}, 64'(zero), 64'(v.r == '0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time 0x%0h", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    logic seen;

    // Reset values while reset is asserted.
    repeat (2) @(negedge clk);
    chk("reset result",    64'(result),    64'd0);
    chk("reset zero",      64'(zero),      64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready",  64'(in_ready),  64'd0);
    chk("reset busy",      64'(busy),      64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i], bc);
      if (vecs[i].name == "SLL 31") chk("SLL 31 busy cycles", 64'(bc), 64'd31);
    end

    // Backpressure: op1 held, op2 waits, then retire+accept together.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    operation = 4'd2; src_a = 32'd1; src_b = 32'd2;
    @(posedge clk); #1;
    operation = 4'd3; src_a = 32'h0000_00F0; src_b = 32'h0000_000F;
    repeat (3) begin
      @(negedge clk);
      chk("bp in_ready low", 64'(in_ready),  64'd0);
      chk("bp out_valid",    64'(out_valid), 64'd1);
      chk("bp result held",  64'(result),    64'd3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp in_ready high", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp op2 valid",  64'(out_valid), 64'd1);
    chk("bp op2 result", 64'(result),    64'h0000_00FF);
    @(posedge clk); #1;

    // Flush three cycles into SLL by 20.
    in_valid = 1'b1; operation = 4'd13; src_a = 32'd1; src_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush busy",      64'(busy),      64'd0);
    chk("flush in_ready",  64'(in_ready),  64'd1);
    chk("flush result kept", 64'(result),  64'h0000_00FF);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush no out_valid", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a shift.
    in_valid = 1'b1; operation = 4'd13; src_a = 32'd1; src_b = 32'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst busy",      64'(busy),      64'd0);
    chk("midrst result",    64'(result),    64'd0);
    chk("midrst zero",      64'(zero),      64'd1);
    chk("midrst in_ready",  64'(in_ready),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mixed traffic checked by the model alone.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      operation = 4'($urandom_range(0, 15));
      src_a     = (k % 5 == 0) ? 32'h8000_0000 : $urandom;
      src_b     = (operation >= 4'd13) ? 32'($urandom_range(0, 7)) :
                  ((k % 7 == 0) ? src_a : $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
